hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Hazard detection and stall/flush controller for the 5-stage pipeline, sitting in the decode stage directly upstream of the forwarding unit. It generates the STALL and FLUSH controls that the forwarding unit, IF/ID register, PC and ID/EXE register consume. It covers the hazards forwarding cannot resolve:
- load-use dependences;
- branch operands still being produced in EXE or MEM;
- squashing the wrong-path fetch after a branch taken in ID.

## Interface
Parameters:
- STATS_WIDTH, 16, width of each hazard statistics counter

Ports:
- CLOCK  in  1  pipeline clock, rising edge
- RESET  in  1  synchronous, active-high reset
- OpcodeID_IN  in  6  opcode of the instruction in ID
- IDRegisterRS_IN  in  5  RS field of the ID instruction
- IDRegisterRT_IN  in  5  RT field of the ID instruction
- UsesRS_IN  in  1  ID instruction reads RS
- UsesRT_IN  in  1  ID instruction reads RT
- writeRDIDEXE  in  5  destination of the instruction in EXE
- writeEnableIDEXE  in  1  EXE instruction writes a register
- MemReadIDEXE  in  1  EXE instruction is a load
- writeRDEXEMEM  in  5  destination of the instruction in MEM
- writeEnableEXEMEM  in  1  MEM instruction writes a register
- MemReadEXEMEM  in  1  MEM instruction is a load
- AltPCEnable_IN  in  1  branch or jump in ID resolved taken
- STALL_OUT  out  1  hold PC and IF/ID; insert a bubble into ID/EXE
- PCWriteEnable_OUT  out  1  equals !STALL_OUT
- FLUSH_OUT  out  1  squash the IF/ID contents on the next edge
- LoadUseCount_OUT  out  STATS_WIDTH  load-use stall events
- BranchStallCount_OUT  out  STATS_WIDTH  branch-operand stall cycles
- FlushCount_OUT  out  STATS_WIDTH  flushes issued

## Operation
- The ID instruction is a branch when OpcodeID_IN ∈ {1,4,5,6,7}.
- matchE(r) = writeEnableIDEXE && writeRDIDEXE!=0 && writeRDIDEXE==r.
- matchM(r) = writeEnableEXEMEM && writeRDEXEMEM!=0 && writeRDEXEMEM==r.
- Only RS/RT values qualified by UsesRS_IN/UsesRT_IN are checked.
- Hazard classes, evaluated in state RUN only:
  - LU (load-use, non-branch): MemReadIDEXE && matchE. Stall 1 cycle.
  - BE (branch, ALU producer in EXE): branch && !MemReadIDEXE && matchE. Stall 1 cycle.
  - BL (branch, load producer in EXE): branch && MemReadIDEXE && matchE. Stall 2 cycles.
  - BM (branch, load producer in MEM): branch && MemReadEXEMEM && matchM. Stall 1 cycle.
- Class priority: BL > BE = LU > BM. Exactly one class is counted per detection.
- FSM states:
  - RUN: STALL_OUT = any hazard class. BL moves to HOLD1; every other case stays in RUN.
  - HOLD1: STALL_OUT=1 unconditionally and inputs are ignored. Next state is RUN.
- FLUSH_OUT = AltPCEnable_IN && !STALL_OUT && state==RUN.
  - Stall has priority: a branch resolved on stale operands never flushes.
- Reset values: state RUN, all counters 0.
  - While RESET=1: STALL_OUT=0, FLUSH_OUT=0, PCWriteEnable_OUT=1.
  - RESET asserted in HOLD1 aborts the hold; the next cycle is RUN.

## Timing
- STALL_OUT, FLUSH_OUT and PCWriteEnable_OUT are combinational from the inputs and state, with zero-cycle latency. They are valid before the edge of the cycle in which the hazard exists.
- State and counters update on the rising CLOCK edge.
- Counter values reflect an event one cycle after the event cycle.
- BL: stall asserted in cycles T and T+1. Cycle T+2 re-evaluates normally; the load is then in WB, no hazard remains, and the branch proceeds using the forwarded value.
- Simultaneous LU and BM cannot occur, since the branch qualifier is exclusive. BL plus AltPCEnable_IN gives stall with no flush.
- Counters saturate at 2^STATS_WIDTH-1 and do not wrap.

## Configuration
- HAZARD_STATS_EN defined: the three counters are implemented.
  - LoadUseCount_OUT increments once per LU detection.
  - BranchStallCount_OUT increments on every stall cycle caused by BE, BL or BM, so BL adds 2.
  - FlushCount_OUT increments on every cycle with FLUSH_OUT=1.
- HAZARD_STATS_EN undefined: no counter registers are built. The ports remain and are tied to 0.

## Test plan
- Load-use: EXE holds a load to $8; ID holds add using $8 as RS. Required: STALL_OUT=1 and PCWriteEnable_OUT=0 for 1 cycle, then 0. LoadUseCount_OUT goes 0→1.
- Branch after ALU op: EXE writes $9; ID is beq (op 4) with RT=$9. Required: 1 stall cycle, then FLUSH_OUT=1 when AltPCEnable_IN=1.
- Branch after load: EXE holds a load to $10; ID is bne (op 5) with RS=$10. Required: STALL_OUT=1 for exactly 2 cycles even if the EXE inputs go to 0. BranchStallCount_OUT=2.
- Register zero and unused operands: EXE load to $0, or a match on RT with UsesRT_IN=0. Required: STALL_OUT=0 throughout.
- Taken branch with no hazard: AltPCEnable_IN=1 and no matches. Required: FLUSH_OUT=1 in the same cycle, FlushCount_OUT=1.
- Reset mid-hold: assert RESET in HOLD1. Required: outputs go to their reset values that cycle; the next cycle is RUN with STALL_OUT=0 and all counters 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard detector: load-use and branch-operand stalls, wrong-path fetch flush.
// Zero-cycle combinational STALL/FLUSH; HAZARD_STATS_EN builds saturating event counters.
module hazard_stall_ctrl #(
    parameter int STATS_WIDTH = 16
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    input  logic [5:0]             OpcodeID_IN,
    input  logic [4:0]             IDRegisterRS_IN,
    input  logic [4:0]             IDRegisterRT_IN,
    input  logic                   UsesRS_IN,
    input  logic                   UsesRT_IN,
    input  logic [4:0]             writeRDIDEXE,
    input  logic                   writeEnableIDEXE,
    input  logic                   MemReadIDEXE,
    input  logic [4:0]             writeRDEXEMEM,
    input  logic                   writeEnableEXEMEM,
    input  logic                   MemReadEXEMEM,
    input  logic                   AltPCEnable_IN,
    output logic                   STALL_OUT,
    output logic                   PCWriteEnable_OUT,
    output logic                   FLUSH_OUT,
    output logic [STATS_WIDTH-1:0] LoadUseCount_OUT,
    output logic [STATS_WIDTH-1:0] BranchStallCount_OUT,
    output logic [STATS_WIDTH-1:0] FlushCount_OUT
);

    typedef enum logic {S_RUN, S_HOLD1} state_t;

    state_t state_q, state_d;
    logic   is_branch;
    logic   hit_e, hit_m;
    logic   lu_hz, be_hz, bl_hz, bm_hz;
    logic   stall, flush;

    always_comb begin
        is_branch = 1'b0;
        case (OpcodeID_IN)
            6'd1, 6'd4, 6'd5, 6'd6, 6'd7: is_branch = 1'b1;
            default:                      is_branch = 1'b0;
        endcase
    end

    // Register $0 is never a real dependence, so a zero destination never matches.
    assign hit_e = writeEnableIDEXE && (writeRDIDEXE != 5'd0) &&
                   ((UsesRS_IN && (writeRDIDEXE == IDRegisterRS_IN)) ||
                    (UsesRT_IN && (writeRDIDEXE == IDRegisterRT_IN)));
    assign hit_m = writeEnableEXEMEM && (writeRDEXEMEM != 5'd0) &&
                   ((UsesRS_IN && (writeRDEXEMEM == IDRegisterRS_IN)) ||
                    (UsesRT_IN && (writeRDEXEMEM == IDRegisterRT_IN)));

    assign lu_hz = !is_branch && MemReadIDEXE && hit_e;
    assign be_hz = is_branch && !MemReadIDEXE && hit_e;
    assign bl_hz = is_branch && MemReadIDEXE && hit_e;
    assign bm_hz = is_branch && MemReadEXEMEM && hit_m;

    always_ff @(posedge CLOCK) begin
        if (RESET) state_q <= S_RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        flush   = 1'b0;
        case (state_q)
            S_RUN: begin
                stall = lu_hz || be_hz || bl_hz || bm_hz;
                flush = AltPCEnable_IN && !stall;
                if (bl_hz) state_d = S_HOLD1;
            end
            S_HOLD1: begin
                stall   = 1'b1;
                state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
        if (RESET) begin
            state_d = S_RUN;
            stall   = 1'b0;
            flush   = 1'b0;
        end
    end

    assign STALL_OUT         = stall;
    assign PCWriteEnable_OUT = !stall;
    assign FLUSH_OUT         = flush;

`ifdef HAZARD_STATS_EN
    logic [STATS_WIDTH-1:0] lu_cnt_q, lu_cnt_d;
    logic [STATS_WIDTH-1:0] br_cnt_q, br_cnt_d;
    logic [STATS_WIDTH-1:0] fl_cnt_q, fl_cnt_d;
    logic                   lu_evt, br_evt;

    function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] v);
        if (v == {STATS_WIDTH{1'b1}}) return v;
        return v + STATS_WIDTH'(1);
    endfunction

    // A HOLD1 cycle is the second stall cycle of a load-fed branch, so it counts too.
    assign lu_evt = !RESET && (state_q == S_RUN) && lu_hz;
    assign br_evt = !RESET && ((state_q == S_HOLD1) ||
                               ((state_q == S_RUN) && (be_hz || bl_hz || bm_hz)));

    always_comb begin
        lu_cnt_d = lu_evt ? sat_inc(lu_cnt_q) : lu_cnt_q;
        br_cnt_d = br_evt ? sat_inc(br_cnt_q) : br_cnt_q;
        fl_cnt_d = flush  ? sat_inc(fl_cnt_q) : fl_cnt_q;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            lu_cnt_q <= '0;
            br_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            lu_cnt_q <= lu_cnt_d;
            br_cnt_q <= br_cnt_d;
            fl_cnt_q <= fl_cnt_d;
        end
    end

    assign LoadUseCount_OUT     = lu_cnt_q;
    assign BranchStallCount_OUT = br_cnt_q;
    assign FlushCount_OUT       = fl_cnt_q;
`else
    assign LoadUseCount_OUT     = '0;
    assign BranchStallCount_OUT = '0;
    assign FlushCount_OUT       = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios with literal checks plus a per-cycle reference model.
module tb_hazard_stall_ctrl;
    localparam int SW   = 4;
    localparam int MAXC = (1 << SW) - 1;
`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          CLOCK = 1'b0;
    logic          RESET;
    logic [5:0]    OpcodeID_IN;
    logic [4:0]    IDRegisterRS_IN, IDRegisterRT_IN;
    logic          UsesRS_IN, UsesRT_IN;
    logic [4:0]    writeRDIDEXE, writeRDEXEMEM;
    logic          writeEnableIDEXE, MemReadIDEXE;
    logic          writeEnableEXEMEM, MemReadEXEMEM;
    logic          AltPCEnable_IN;
    logic          STALL_OUT, PCWriteEnable_OUT, FLUSH_OUT;
    logic [SW-1:0] LoadUseCount_OUT, BranchStallCount_OUT, FlushCount_OUT;

    int errors = 0;
    int checks = 0;

    hazard_stall_ctrl #(.STATS_WIDTH(SW)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .OpcodeID_IN(OpcodeID_IN), .IDRegisterRS_IN(IDRegisterRS_IN), .IDRegisterRT_IN(IDRegisterRT_IN),
        .UsesRS_IN(UsesRS_IN), .UsesRT_IN(UsesRT_IN),
        .writeRDIDEXE(writeRDIDEXE), .writeEnableIDEXE(writeEnableIDEXE), .MemReadIDEXE(MemReadIDEXE),
        .writeRDEXEMEM(writeRDEXEMEM), .writeEnableEXEMEM(writeEnableEXEMEM), .MemReadEXEMEM(MemReadEXEMEM),
        .AltPCEnable_IN(AltPCEnable_IN),
        .STALL_OUT(STALL_OUT), .PCWriteEnable_OUT(PCWriteEnable_OUT), .FLUSH_OUT(FLUSH_OUT),
        .LoadUseCount_OUT(LoadUseCount_OUT), .BranchStallCount_OUT(BranchStallCount_OUT),
        .FlushCount_OUT(FlushCount_OUT)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_hold = 0;
    int m_lu = 0, m_br = 0, m_fl = 0;
    bit primed = 1'b0;

    function automatic bit prod_hits(input bit we, input logic [4:0] rd);
        if (!we || rd == 5'd0) return 1'b0;
        return (UsesRS_IN && rd == IDRegisterRS_IN) || (UsesRT_IN && rd == IDRegisterRT_IN);
    endfunction

    // cls: 0 none, 1 load-use, 2 branch/ALU-in-EXE, 3 branch/load-in-EXE, 4 branch/load-in-MEM
    function automatic void model_eval(output bit st, output bit fl, output int cls);
        bit br, he, hm;
        cls = 0;
        if (RESET) begin st = 0; fl = 0; return; end
        if (m_hold > 0) begin st = 1; fl = 0; return; end
        br = OpcodeID_IN inside {6'd1, 6'd4, 6'd5, 6'd6, 6'd7};
        he = prod_hits(writeEnableIDEXE, writeRDIDEXE);
        hm = prod_hits(writeEnableEXEMEM, writeRDEXEMEM);
        if (br && he && MemReadIDEXE)        cls = 3;
        else if (br && he)                   cls = 2;
        else if (!br && he && MemReadIDEXE)  cls = 1;
        else if (br && hm && MemReadEXEMEM)  cls = 4;
        st = (cls != 0);
        fl = AltPCEnable_IN && !st;
    endfunction

    function automatic int bump(input int v);
        if (!STATS) return 0;
        return (v < MAXC) ? v + 1 : v;
    endfunction

    always @(posedge CLOCK) begin
        bit es, ef;
        int c;
        model_eval(es, ef, c);
        primed = 1'b1;
        if (RESET) begin
            m_hold = 0; m_lu = 0; m_br = 0; m_fl = 0;
        end else begin
            if (m_hold > 0) begin
                m_hold = m_hold - 1;
                m_br = bump(m_br);
            end else if (c == 3) begin
                m_hold = 1;
                m_br = bump(m_br);
            end else if (c == 1) m_lu = bump(m_lu);
            else if (c != 0)     m_br = bump(m_br);
            if (ef) m_fl = bump(m_fl);
        end
    end

    always @(negedge CLOCK) begin
        bit es, ef;
        int c;
        model_eval(es, ef, c);
        check("model_stall", STALL_OUT, es);
        check("model_pcwe", PCWriteEnable_OUT, !es);
        check("model_flush", FLUSH_OUT, ef);
        if (primed) begin
            check("model_lu_cnt", LoadUseCount_OUT, m_lu);
            check("model_br_cnt", BranchStallCount_OUT, m_br);
            check("model_fl_cnt", FlushCount_OUT, m_fl);
        end
    end

    // ---------------- stimulus ----------------
    task automatic clr();
        OpcodeID_IN = 6'd0; IDRegisterRS_IN = 5'd0; IDRegisterRT_IN = 5'd0;
        UsesRS_IN = 1'b0; UsesRT_IN = 1'b0;
        writeRDIDEXE = 5'd0; writeEnableIDEXE = 1'b0; MemReadIDEXE = 1'b0;
        writeRDEXEMEM = 5'd0; writeEnableEXEMEM = 1'b0; MemReadEXEMEM = 1'b0;
        AltPCEnable_IN = 1'b0;
    endtask

    task automatic cyc();
        @(posedge CLOCK);
        #1;
        clr();
    endtask

    task automatic settle();
        @(negedge CLOCK);
    endtask

    task automatic lit(input string nm, input bit st, input bit fl);
        check({nm, "_stall"}, STALL_OUT, st);
        check({nm, "_pcwe"}, PCWriteEnable_OUT, !st);
        check({nm, "_flush"}, FLUSH_OUT, fl);
    endtask

    initial begin
        clr();
        RESET = 1'b1;
        // Reset forces outputs even with a live load-use and a taken branch present.
        OpcodeID_IN = 6'd0; IDRegisterRS_IN = 5'd8; UsesRS_IN = 1'b1;
        writeRDIDEXE = 5'd8; writeEnableIDEXE = 1'b1; MemReadIDEXE = 1'b1; AltPCEnable_IN = 1'b1;
        settle();
        lit("in_reset", 0, 0);
        cyc(); RESET = 1'b1; settle();
        cyc(); RESET = 1'b0; settle();
        lit("idle", 0, 0);
        check("rst_lu_cnt", LoadUseCount_OUT, 0);
        check("rst_br_cnt", BranchStallCount_OUT, 0);
        check("rst_fl_cnt", FlushCount_OUT, 0);

        // Load-use on $8
        cyc(); IDRegisterRS_IN = 5'd8; UsesRS_IN = 1'b1;
        writeRDIDEXE = 5'd8; writeEnableIDEXE = 1'b1; MemReadIDEXE = 1'b1; settle();
        lit("lu", 1, 0);
        cyc(); IDRegisterRS_IN = 5'd8; UsesRS_IN = 1'b1; settle();
        lit("lu_after", 0, 0);
        check("lu_cnt", LoadUseCount_OUT, STATS ? 1 : 0);

        // beq after ALU write of $9, taken
        cyc(); OpcodeID_IN = 6'd4; IDRegisterRT_IN = 5'd9; UsesRT_IN = 1'b1; AltPCEnable_IN = 1'b1;
        writeRDIDEXE = 5'd9; writeEnableIDEXE = 1'b1; settle();
        lit("be", 1, 0);
        cyc(); OpcodeID_IN = 6'd4; IDRegisterRT_IN = 5'd9; UsesRT_IN = 1'b1; AltPCEnable_IN = 1'b1;
        writeRDEXEMEM = 5'd9; writeEnableEXEMEM = 1'b1; settle();
        lit("be_after", 0, 1);
        check("be_br_cnt", BranchStallCount_OUT, STATS ? 1 : 0);

        // bne after load of $10: two stall cycles, second ignores inputs
        cyc(); OpcodeID_IN = 6'd5; IDRegisterRS_IN = 5'd10; UsesRS_IN = 1'b1; AltPCEnable_IN = 1'b1;
        writeRDIDEXE = 5'd10; writeEnableIDEXE = 1'b1; MemReadIDEXE = 1'b1; settle();
        lit("bl_t0", 1, 0);
        cyc(); OpcodeID_IN = 6'd5; IDRegisterRS_IN = 5'd10; UsesRS_IN = 1'b1; AltPCEnable_IN = 1'b1; settle();
        lit("bl_t1", 1, 0);
        cyc(); OpcodeID_IN = 6'd5; IDRegisterRS_IN = 5'd10; UsesRS_IN = 1'b1; AltPCEnable_IN = 1'b1; settle();
        lit("bl_t2", 0, 1);
        check("bl_br_cnt", BranchStallCount_OUT, STATS ? 3 : 0);
        check("bl_fl_cnt", FlushCount_OUT, STATS ? 1 : 0);

        // $0 destination and unused RT never stall
        cyc(); UsesRS_IN = 1'b1; writeEnableIDEXE = 1'b1; MemReadIDEXE = 1'b1; settle();
        lit("reg0", 0, 0);
        cyc(); IDRegisterRT_IN = 5'd12; writeRDIDEXE = 5'd12; writeEnableIDEXE = 1'b1; MemReadIDEXE = 1'b1; settle();
        lit("unused_rt", 0, 0);

        // blez with load to $3 in MEM, taken: stall wins over flush
        cyc(); OpcodeID_IN = 6'd6; IDRegisterRS_IN = 5'd3; UsesRS_IN = 1'b1; AltPCEnable_IN = 1'b1;
        writeRDEXEMEM = 5'd3; writeEnableEXEMEM = 1'b1; MemReadEXEMEM = 1'b1; settle();
        lit("bm", 1, 0);

        // Taken branch with no hazard
        cyc(); OpcodeID_IN = 6'd1; AltPCEnable_IN = 1'b1; settle();
        lit("taken", 0, 1);
        check("taken_fl_cnt", FlushCount_OUT, STATS ? 2 : 0);
        cyc(); settle();
        check("taken_fl_cnt2", FlushCount_OUT, STATS ? 3 : 0);
        check("bm_br_cnt", BranchStallCount_OUT, STATS ? 4 : 0);

        // Reset asserted during HOLD1
        cyc(); OpcodeID_IN = 6'd7; IDRegisterRT_IN = 5'd4; UsesRT_IN = 1'b1;
        writeRDIDEXE = 5'd4; writeEnableIDEXE = 1'b1; MemReadIDEXE = 1'b1; settle();
        lit("hold_entry", 1, 0);
        cyc(); RESET = 1'b1; AltPCEnable_IN = 1'b1; settle();
        lit("hold_reset", 0, 0);
        cyc(); RESET = 1'b0; settle();
        lit("post_reset", 0, 0);
        check("post_rst_lu", LoadUseCount_OUT, 0);
        check("post_rst_br", BranchStallCount_OUT, 0);
        check("post_rst_fl", FlushCount_OUT, 0);

        // Flush counter saturation
        for (int i = 0; i < MAXC + 5; i++) begin
            cyc(); OpcodeID_IN = 6'd4; AltPCEnable_IN = 1'b1; settle();
        end
        cyc(); settle();
        check("sat_fl_cnt", FlushCount_OUT, STATS ? MAXC : 0);

        // Pseudo-random traffic checked by the model only
        for (int i = 0; i < 400; i++) begin
            cyc();
            RESET             = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 6))
                0: OpcodeID_IN = 6'd0;
                1: OpcodeID_IN = 6'd35;
                2: OpcodeID_IN = 6'd1;
                3: OpcodeID_IN = 6'd4;
                4: OpcodeID_IN = 6'd5;
                5: OpcodeID_IN = 6'd6;
                default: OpcodeID_IN = 6'd7;
            endcase
            IDRegisterRS_IN   = 5'($urandom_range(0, 3));
            IDRegisterRT_IN   = 5'($urandom_range(0, 3));
            UsesRS_IN         = 1'($urandom_range(0, 1));
            UsesRT_IN         = 1'($urandom_range(0, 1));
            writeRDIDEXE      = 5'($urandom_range(0, 3));
            writeEnableIDEXE  = 1'($urandom_range(0, 1));
            MemReadIDEXE      = 1'($urandom_range(0, 1));
            writeRDEXEMEM     = 5'($urandom_range(0, 3));
            writeEnableEXEMEM = 1'($urandom_range(0, 1));
            MemReadEXEMEM     = 1'($urandom_range(0, 1));
            AltPCEnable_IN    = 1'($urandom_range(0, 1));
            settle();
        end
        cyc(); RESET = 1'b0; settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
